// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of every signal exchanged between mem_arbiter and its
//               surroundings: IF fetch port, LS port, byte-wide RAM/IO bus,
//               global enable and status.
//               slave  : seen from the arbiter (requests in, RAM bus out)
//               master : seen from the pipeline / RAM side
// Ports       : none (pure signal bundle; clk/rst are wired separately)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   // global enable
   logic              rdy;

   // instruction fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [31:0]       if_data;
   logic              flush;

   // load/store port
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [31:0]       ls_wdata;
   logic [2:0]        ls_size;
   logic              ls_ack;
   logic [31:0]       ls_rdata;

   // byte-wide RAM / IO bus
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wr;
   logic [7:0]        ram_dout;
   logic [7:0]        ram_din;
   logic              io_buffer_full;

   // status
   logic              busy;

   modport slave (
      input  rdy,
      input  if_req, if_addr, flush,
      output if_ack, if_data,
      input  ls_req, ls_we, ls_addr, ls_wdata, ls_size,
      output ls_ack, ls_rdata,
      output ram_addr, ram_wr, ram_dout,
      input  ram_din, io_buffer_full,
      output busy
   );

   modport master (
      output rdy,
      output if_req, if_addr, flush,
      input  if_ack, if_data,
      output ls_req, ls_we, ls_addr, ls_wdata, ls_size,
      input  ls_ack, ls_rdata,
      input  ram_addr, ram_wr, ram_dout,
      output ram_din, io_buffer_full,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one byte-wide RAM port between instruction fetch (IF)
//               and the load/store unit (LS). Each granted request is split
//               into consecutive byte transfers and the result is returned
//               as one assembled 32-bit word with a single-cycle ack.
//               LS normally wins arbitration; IF is forced through after
//               STARVE_MAX consecutive LS grants. LS writes to the I/O region
//               are held back while the I/O write buffer is full.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - mem_arbiter_if.slave: IF port, LS port, RAM bus,
//                      rdy global enable, io_buffer_full, busy
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int         ADDR_W     = 32,
   parameter int         STARVE_MAX = 4,
   parameter logic [1:0] IO_HI      = 2'b11
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_RD   = 2'd1;
   localparam logic [1:0] C_WR   = 2'd2;

   localparam int                 C_SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [C_SW-1:0]    C_STARVE_MAX = C_SW'(STARVE_MAX);
   localparam logic [ADDR_W-1:0]  C_ADDR_ONE   = ADDR_W'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]        state_q,    state_d;
   logic              src_ls_q,   src_ls_d;    // 1 = LS owns the transaction
   logic [2:0]        n_q,        n_d;         // byte count: 1, 2 or 4
   logic [2:0]        cnt_q,      cnt_d;       // edges elapsed since grant
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_wr_q,   ram_wr_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic [31:0]       wdata_q,    wdata_d;
   logic [31:0]       rdata_q,    rdata_d;
   logic              if_ack_q,   if_ack_d;
   logic [31:0]       if_data_q,  if_data_d;
   logic              ls_ack_q,   ls_ack_d;
   logic [31:0]       ls_rdata_q, ls_rdata_d;
   logic [C_SW-1:0]   starve_q,   starve_d;
   logic              flush_q,    flush_d;     // sticky flush for current IF read

   // ------------------------------------------------------------------------
   // Arbitration terms
   // ------------------------------------------------------------------------
   logic       w_ls_io;
   logic       w_ls_elig;
   logic       w_if_elig;
   logic       w_arb_en;
   logic       w_grant_ls;
   logic       w_grant_if;
   logic [2:0] w_ls_n;
   logic [2:0] w_edge;     // index of the edge being evaluated, counted from grant
   logic [2:0] w_off;
   logic [1:0] w_idx;      // byte lane sampled at this edge during a read

   assign w_ls_io   = (bus.ls_addr[17:16] == IO_HI);
   assign w_ls_elig = bus.ls_req & ~(bus.ls_we & w_ls_io & bus.io_buffer_full);
   assign w_if_elig = bus.if_req & ~bus.flush;

   // The idle cycle that carries an ack is a forced dead cycle, so a requester
   // that drops its request on the ack is never granted twice.
   assign w_arb_en  = (state_q == C_IDLE) & ~if_ack_q & ~ls_ack_q;

   assign w_grant_ls = w_arb_en & w_ls_elig & (~w_if_elig | (starve_q < C_STARVE_MAX));
   assign w_grant_if = w_arb_en & w_if_elig & ~w_grant_ls;

   // Unsupported sizes fall back to a full word.
   always_comb begin
      case (bus.ls_size)
         3'd1:    w_ls_n = 3'd1;
         3'd2:    w_ls_n = 3'd2;
         default: w_ls_n = 3'd4;
      endcase
   end

   assign w_edge = cnt_q + 3'd1;
   assign w_off  = w_edge - 3'd2;
   assign w_idx  = w_off[1:0];

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      src_ls_d   = src_ls_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      ram_addr_d = ram_addr_q;
      ram_wr_d   = ram_wr_q;
      ram_dout_d = ram_dout_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      if_ack_d   = 1'b0;
      if_data_d  = if_data_q;
      ls_ack_d   = 1'b0;
      ls_rdata_d = ls_rdata_q;
      flush_d    = flush_q;

      case (state_q)
         C_IDLE: begin
            ram_addr_d = '0;
            ram_wr_d   = 1'b0;
            if (w_grant_ls) begin
               src_ls_d   = 1'b1;
               n_d        = w_ls_n;
               cnt_d      = 3'd0;
               ram_addr_d = bus.ls_addr;
               wdata_d    = bus.ls_wdata;
               rdata_d    = '0;
               flush_d    = 1'b0;
               if (bus.ls_we) begin
                  ram_wr_d   = 1'b1;
                  ram_dout_d = bus.ls_wdata[7:0];
                  state_d    = C_WR;
               end else begin
                  state_d    = C_RD;
               end
            end else if (w_grant_if) begin
               src_ls_d   = 1'b0;
               n_d        = 3'd4;
               cnt_d      = 3'd0;
               ram_addr_d = bus.if_addr;
               rdata_d    = '0;
               flush_d    = bus.flush;
               state_d    = C_RD;
            end
         end

         C_RD: begin
            cnt_d = w_edge;
            if (!src_ls_q && bus.flush) begin
               flush_d = 1'b1;
            end
            // Addresses run one edge ahead of the data because RAM has a
            // one-cycle read latency; once the last byte is presented the
            // bus is parked at 0.
            if (w_edge < n_q) begin
               ram_addr_d = ram_addr_q + C_ADDR_ONE;
            end else begin
               ram_addr_d = '0;
            end
            if (w_edge >= 3'd2) begin
               rdata_d[{w_idx, 3'b000} +: 8] = bus.ram_din;
            end
            if (w_edge == (n_q + 3'd1)) begin
               state_d = C_IDLE;
               if (src_ls_q) begin
                  ls_ack_d   = 1'b1;
                  ls_rdata_d = rdata_d;
               end else if (!(flush_q || bus.flush)) begin
                  // A flushed fetch still finishes on the bus, but its
                  // result is dropped silently.
                  if_ack_d  = 1'b1;
                  if_data_d = rdata_d;
               end
            end
         end

         C_WR: begin
            cnt_d = w_edge;
            if (w_edge < n_q) begin
               ram_addr_d = ram_addr_q + C_ADDR_ONE;
               ram_dout_d = wdata_q[{w_edge[1:0], 3'b000} +: 8];
            end else begin
               ram_wr_d   = 1'b0;
               ram_addr_d = '0;
               ls_ack_d   = 1'b1;
               state_d    = C_IDLE;
            end
         end

         default: begin
            state_d    = C_IDLE;
            ram_addr_d = '0;
            ram_wr_d   = 1'b0;
         end
      endcase
   end

   // Starvation counter: counts LS wins while IF is waiting; any cycle where
   // IF is not requesting, or an IF grant, restarts the count.
   always_comb begin
      starve_d = starve_q;
      if (!bus.if_req || w_grant_if) begin
         starve_d = '0;
      end else if (w_grant_ls && (starve_q < C_STARVE_MAX)) begin
         starve_d = starve_q + C_SW'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Registers: rdy low freezes everything, acks included
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= C_IDLE;
         src_ls_q   <= 1'b0;
         n_q        <= 3'd0;
         cnt_q      <= 3'd0;
         ram_addr_q <= '0;
         ram_wr_q   <= 1'b0;
         ram_dout_q <= 8'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         if_ack_q   <= 1'b0;
         if_data_q  <= 32'd0;
         ls_ack_q   <= 1'b0;
         ls_rdata_q <= 32'd0;
         starve_q   <= '0;
         flush_q    <= 1'b0;
      end else if (bus.rdy) begin
         state_q    <= state_d;
         src_ls_q   <= src_ls_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         ram_addr_q <= ram_addr_d;
         ram_wr_q   <= ram_wr_d;
         ram_dout_q <= ram_dout_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         if_ack_q   <= if_ack_d;
         if_data_q  <= if_data_d;
         ls_ack_q   <= ls_ack_d;
         ls_rdata_q <= ls_rdata_d;
         starve_q   <= starve_d;
         flush_q    <= flush_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_wr   = ram_wr_q;
   assign bus.ram_dout = ram_dout_q;
   assign bus.if_ack   = if_ack_q;
   assign bus.if_data  = if_data_q;
   assign bus.ls_ack   = ls_ack_q;
   assign bus.ls_rdata = ls_rdata_q;
   assign bus.busy     = (state_q != C_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a byte RAM model,
//               an expected-transaction queue and a RAM write log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst;

   mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4), .IO_HI(2'b11)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_ls;
      bit          chk_data;
      logic [31:0] data;
      int          lat;      // edges after grant; -1 = not checked
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   exp_t        exp_q[$];
   wr_t         exp_wr[$];
   wr_t         wr_log[$];
   logic [31:0] addr_trace[$];
   logic [7:0]  mem [bit [31:0]];

   int n_pass  = 0;
   int n_total = 0;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'hA5;
   endfunction

   // Byte RAM: one-cycle read latency, held with the global enable.
   always @(posedge clk) begin
      if (bus.rdy) begin
         bus.ram_din <= mem_byte(bus.ram_addr);
         if (bus.ram_wr) begin
            mem[bus.ram_addr] = bus.ram_dout;
            wr_log.push_back('{addr: bus.ram_addr, data: bus.ram_dout});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advances until an ack appears or the budget runs out; records ram_addr.
   task automatic wait_ack(input int budget, output int edges, output bit to);
      edges = 0;
      to    = 1'b1;
      addr_trace.delete();
      for (int c = 0; c < budget; c++) begin
         step();
         edges++;
         addr_trace.push_back(bus.ram_addr);
         if (bus.if_ack || bus.ls_ack) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic idle_inputs();
      bus.if_req = 0; bus.if_addr = '0; bus.flush = 0;
      bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_size = 3'd4;
      bus.io_buffer_full = 0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1; bus.rdy = 1; idle_inputs();
      step(); step();
      n_total++;
      if ({bus.ram_addr, bus.ram_wr, bus.ram_dout, bus.if_ack, bus.ls_ack, bus.if_data, bus.ls_rdata} !== '0)
         $display("FAIL reset_outputs: got addr=%h wr=%b dout=%h ifa=%b lsa=%b ifd=%h lsd=%h expected all 0",
                  bus.ram_addr, bus.ram_wr, bus.ram_dout, bus.if_ack, bus.ls_ack, bus.if_data, bus.ls_rdata);
      else n_pass++;
      n_total++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
      rst = 0;
      step();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_if_read();
      int edges; bit to; exp_t e;
      logic [31:0] exp_tr [6];
      exp_tr = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0};
      exp_q.push_back('{is_ls: 0, chk_data: 1, data: 32'h9300_0013, lat: 5});
      bus.if_req = 1; bus.if_addr = 32'h100;
      wait_ack(20, edges, to);
      e = exp_q.pop_front();
      n_total++;
      if (to) $display("FAIL if_read_timeout: got no ack expected ack"); else n_pass++;
      n_total++;
      if (bus.if_ack !== 1'b1 || bus.ls_ack !== 1'b0)
         $display("FAIL if_read_src: got if_ack=%b ls_ack=%b expected 1/0", bus.if_ack, bus.ls_ack);
      else n_pass++;
      n_total++;
      if (bus.if_data !== e.data) $display("FAIL if_read_data: got %h expected %h", bus.if_data, e.data); else n_pass++;
      n_total++;
      if (edges - 1 !== e.lat) $display("FAIL if_read_latency: got %0d expected %0d", edges - 1, e.lat); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if (addr_trace.size() <= i || addr_trace[i] !== exp_tr[i])
            $display("FAIL if_read_addr%0d: got %h expected %h", i,
                     (addr_trace.size() > i) ? addr_trace[i] : 32'hxxxx_xxxx, exp_tr[i]);
         else n_pass++;
      end
      bus.if_req = 0;
      step();
      n_total++;
      if (bus.busy !== 1'b0 || bus.if_ack !== 1'b0)
         $display("FAIL if_read_after: got busy=%b if_ack=%b expected 0/0", bus.busy, bus.if_ack);
      else n_pass++;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_ls_write();
      int edges; bit to; wr_t w;
      wr_log.delete();
      exp_wr.push_back('{addr: 32'h1002, data: 8'hDD});
      exp_wr.push_back('{addr: 32'h1003, data: 8'hCC});
      bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h1002; bus.ls_size = 3'd2; bus.ls_wdata = 32'hAABB_CCDD;
      step();  // grant edge
      n_total++;
      if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 32'h1002 || bus.ram_dout !== 8'hDD)
         $display("FAIL ls_write_first: got wr=%b addr=%h dout=%h expected 1/1002/dd", bus.ram_wr, bus.ram_addr, bus.ram_dout);
      else n_pass++;
      // inputs changed after the grant must not matter
      bus.ls_wdata = 32'h0; bus.ls_size = 3'd4;
      wait_ack(10, edges, to);
      n_total++;
      if (to || bus.ls_ack !== 1'b1 || edges !== 2)
         $display("FAIL ls_write_ack: got ls_ack=%b latency=%0d expected 1 at 2", bus.ls_ack, edges);
      else n_pass++;
      bus.ls_req = 0; bus.ls_we = 0;
      step(); step();
      n_total++;
      if (wr_log.size() !== 2) $display("FAIL ls_write_count: got %0d expected 2", wr_log.size()); else n_pass++;
      while (exp_wr.size() > 0) begin
         w = exp_wr.pop_front();
         n_total++;
         if (wr_log.size() == 0) $display("FAIL ls_write_byte: got none expected %h@%h", w.data, w.addr);
         else begin
            if (wr_log[0].addr !== w.addr || wr_log[0].data !== w.data)
               $display("FAIL ls_write_byte: got %h@%h expected %h@%h", wr_log[0].data, wr_log[0].addr, w.data, w.addr);
            else n_pass++;
            void'(wr_log.pop_front());
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_ls_read();
      int edges; bit to; exp_t e;
      logic [31:0] t_addr [5];
      logic [2:0]  t_size [5];
      logic [31:0] t_data [5];
      int          t_lat  [5];
      t_addr = '{32'h1002, 32'h100, 32'hFFFF_FFFF, 32'h3_0004, 32'h40};
      t_size = '{3'd2, 3'd3, 3'd2, 3'd1, 3'd0};
      t_data = '{32'h0000_CCDD, 32'h9300_0013, 32'h0000_A55A, 32'h0000_00A1, 32'hE6E7_E4E5};
      t_lat  = '{3, 5, 3, 2, 5};
      bus.io_buffer_full = 1;  // must not affect reads, even to I/O
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{is_ls: 1, chk_data: 1, data: t_data[i], lat: t_lat[i]});
         bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = t_addr[i]; bus.ls_size = t_size[i];
         wait_ack(20, edges, to);
         e = exp_q.pop_front();
         n_total++;
         if (to || bus.ls_ack !== 1'b1)
            $display("FAIL ls_read%0d_ack: got ls_ack=%b expected 1", i, bus.ls_ack);
         else n_pass++;
         n_total++;
         if (bus.ls_rdata !== e.data || edges - 1 !== e.lat)
            $display("FAIL ls_read%0d: got %h lat %0d expected %h lat %0d", i, bus.ls_rdata, edges - 1, e.data, e.lat);
         else n_pass++;
         bus.ls_req = 0;
         step();
      end
      bus.io_buffer_full = 0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_starvation();
      int edges; bit to; exp_t e; bit got_ls;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) exp_q.push_back('{is_ls: 1, chk_data: 1, data: 32'h0000_00F5, lat: -1});
         exp_q.push_back('{is_ls: 0, chk_data: 1, data: 32'h9300_0013, lat: -1});
      end
      bus.if_req = 1; bus.if_addr = 32'h100;
      bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h50; bus.ls_size = 3'd1;
      for (int k = 0; k < 10; k++) begin
         wait_ack(20, edges, to);
         e = exp_q.pop_front();
         n_total++;
         if (to) begin
            $display("FAIL starve_timeout%0d: got no ack expected ack", k);
            break;
         end
         got_ls = bus.ls_ack;
         if (got_ls !== e.is_ls || (got_ls ? bus.ls_rdata : bus.if_data) !== e.data)
            $display("FAIL starve_grant%0d: got ls=%b data=%h expected ls=%b data=%h", k, got_ls,
                     got_ls ? bus.ls_rdata : bus.if_data, e.is_ls, e.data);
         else n_pass++;
      end
      exp_q.delete();
      bus.if_req = 0; bus.ls_req = 0;
      step(); step();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_io_hold();
      int edges; bit to; bit act; wr_t w;
      wr_log.delete();
      bus.io_buffer_full = 1;
      bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h3_0000; bus.ls_size = 3'd4; bus.ls_wdata = 32'h1122_3344;
      bus.if_req = 1; bus.if_addr = 32'h100;
      wait_ack(20, edges, to);
      n_total++;
      if (to || bus.if_ack !== 1'b1 || bus.ls_ack !== 1'b0)
         $display("FAIL io_hold_if_first: got if_ack=%b ls_ack=%b expected 1/0", bus.if_ack, bus.ls_ack);
      else n_pass++;
      bus.if_req = 0;
      act = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         act |= bus.busy | bus.ls_ack | bus.ram_wr;
      end
      n_total++;
      if (act !== 1'b0) $display("FAIL io_hold_blocked: got activity=%b expected 0", act); else n_pass++;
      for (int k = 0; k < 4; k++) exp_wr.push_back('{addr: 32'h3_0000 + k, data: 8'h44 - 8'(k * 8'h11)});
      bus.io_buffer_full = 0;
      wait_ack(20, edges, to);
      n_total++;
      if (to || bus.ls_ack !== 1'b1 || edges !== 5)
         $display("FAIL io_hold_release: got ls_ack=%b edges=%0d expected 1 at 5", bus.ls_ack, edges);
      else n_pass++;
      bus.ls_req = 0; bus.ls_we = 0;
      step();
      while (exp_wr.size() > 0) begin
         w = exp_wr.pop_front();
         n_total++;
         if (wr_log.size() == 0) $display("FAIL io_write_byte: got none expected %h@%h", w.data, w.addr);
         else begin
            if (wr_log[0].addr !== w.addr || wr_log[0].data !== w.data)
               $display("FAIL io_write_byte: got %h@%h expected %h@%h", wr_log[0].data, wr_log[0].addr, w.data, w.addr);
            else n_pass++;
            void'(wr_log.pop_front());
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_flush();
      logic [31:0] a [1:10];
      logic        b [1:10];
      bit          ack_seen;
      ack_seen = 0;
      bus.if_req = 1; bus.if_addr = 32'h100;
      for (int s = 1; s <= 10; s++) begin
         step();
         a[s] = bus.ram_addr; b[s] = bus.busy;
         ack_seen |= bus.if_ack;
         if (s == 3) begin bus.flush = 1; bus.if_req = 0; end
         if (s == 4) bus.flush = 0;
      end
      n_total++;
      if (a[4] !== 32'h103 || a[5] !== 32'h0)
         $display("FAIL flush_bus_reads: got %h,%h expected 00000103,00000000", a[4], a[5]);
      else n_pass++;
      n_total++;
      if (ack_seen !== 1'b0) $display("FAIL flush_ack: got %b expected 0", ack_seen); else n_pass++;
      n_total++;
      if (b[5] !== 1'b1 || b[6] !== 1'b0)
         $display("FAIL flush_busy: got %b,%b expected 1,0", b[5], b[6]);
      else n_pass++;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_rdy_stall();
      int edges; bit to; bit frozen;
      exp_q.push_back('{is_ls: 0, chk_data: 1, data: 32'h9300_0013, lat: 8});
      bus.if_req = 1; bus.if_addr = 32'h100;
      step(); step(); step();   // grant, G+1, G+2
      bus.rdy = 0;
      frozen = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         if (bus.ram_addr !== 32'h102 || bus.if_ack !== 1'b0) frozen = 0;
      end
      n_total++;
      if (frozen !== 1'b1) $display("FAIL rdy_freeze: got addr=%h expected 00000102 held", bus.ram_addr); else n_pass++;
      bus.rdy = 1;
      wait_ack(20, edges, to);
      begin
         exp_t e;
         e = exp_q.pop_front();
         n_total++;
         if (to || bus.if_ack !== 1'b1 || bus.if_data !== e.data || (5 + edges) !== e.lat)
            $display("FAIL rdy_stall_ack: got ack=%b data=%h lat=%0d expected 1 %h %0d",
                     bus.if_ack, bus.if_data, 5 + edges, e.data, e.lat);
         else n_pass++;
      end
      bus.if_req = 0;
      step();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid_write();
      bit ack_seen;
      bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h500; bus.ls_size = 3'd4; bus.ls_wdata = 32'hDEAD_BEEF;
      step(); step();
      n_total++;
      if (bus.ram_addr !== 32'h501 || bus.ram_wr !== 1'b1 || bus.ram_dout !== 8'hBE)
         $display("FAIL rst_wr_pre: got addr=%h wr=%b dout=%h expected 501/1/be", bus.ram_addr, bus.ram_wr, bus.ram_dout);
      else n_pass++;
      rst = 1; bus.ls_req = 0; bus.ls_we = 0;
      step();
      n_total++;
      if ({bus.ram_addr, bus.ram_wr, bus.ram_dout, bus.if_ack, bus.ls_ack, bus.busy} !== '0)
         $display("FAIL rst_wr_outputs: got addr=%h wr=%b dout=%h lsa=%b busy=%b expected all 0",
                  bus.ram_addr, bus.ram_wr, bus.ram_dout, bus.ls_ack, bus.busy);
      else n_pass++;
      rst = 0;
      ack_seen = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         ack_seen |= bus.ls_ack | bus.busy;
      end
      n_total++;
      if (ack_seen !== 1'b0) $display("FAIL rst_wr_no_ack: got %b expected 0", ack_seen); else n_pass++;
   endtask

   // ------------------------------------------------------------------------
   initial begin
      mem[32'h100] = 8'h13; mem[32'h101] = 8'h00; mem[32'h102] = 8'h00; mem[32'h103] = 8'h93;
      test_reset();
      test_if_read();
      test_ls_write();
      test_ls_read();
      test_starvation();
      test_io_hold();
      test_flush();
      test_rdy_stall();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store unit (LS).
- Serialises each granted word, halfword or byte request into consecutive byte transfers, then returns an assembled 32-bit result.
- Bounds IF starvation under sustained LS traffic.
- Holds LS writes to the I/O region while the I/O buffer is full.
- Sits between the pipeline front/back ends and the RAM/IO bus.

Parameters:
ADDR_W, 32, address width of requests and RAM address
STARVE_MAX, 4, consecutive LS grants with IF pending before IF is forced to win
IO_HI, 2'b11, value of addr[17:16] that marks the I/O region

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low freezes all state
if_req  in  1  IF read request, level, held until if_ack
if_addr  in  ADDR_W  IF word address
if_ack  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
flush  in  1  discard in-flight/pending IF request
ls_req  in  1  LS request, level, held until ls_ack
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_W  LS byte address
ls_wdata  in  32  write data, byte 0 = [7:0]
ls_size  in  3  bytes: 1, 2, 4 (any other value is treated as 4)
ls_ack  out  1  one-cycle pulse, done (ls_rdata valid for reads)
ls_rdata  out  32  read data, zero-extended
ram_addr  out  ADDR_W  RAM byte address
ram_wr  out  1  1 = write, 0 = read
ram_dout  out  8  write byte
ram_din  in  8  read byte; valid the cycle after ram_addr presents its address
io_buffer_full  in  1  I/O write buffer full
busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset values: outputs 0, state IDLE, starve counter 0. Reset mid-transaction aborts it with no ack.
- rdy=0: every register holds, including acks. Ack pulses are defined in rdy=1 cycles.
- States: IDLE, RD, WR.
- IDLE drives ram_addr=0 and ram_wr=0.
- IDLE ignores requests in any cycle where if_ack or ls_ack is high. This gives one dead cycle between transactions.
- Arbitration in IDLE, evaluated at each edge:
  - LS is eligible if ls_req=1 and not (ls_we=1, addr[17:16]=IO_HI and io_buffer_full=1).
  - IF is eligible if if_req=1 and flush=0.
  - If both are eligible, LS wins unless starve>=STARVE_MAX, in which case IF wins.
- Starve counter:
  - Increments on an LS grant while if_req=1, saturating at STARVE_MAX.
  - Clears on an IF grant or any cycle with if_req=0.
- Grant edge:
  - Latch source, n (IF: 4), and address.
  - Set ram_addr <= addr and byte counter <= 0.
  - Read: next state RD.
  - Write: ram_wr <= 1, ram_dout <= wdata[7:0], next state WR.
- RD:
  - Each edge, ram_addr advances by 1 (modulo 2^ADDR_W) until byte n-1 has been presented, then goes to 0.
  - Byte i is sampled from ram_din at edge grant+i+2 into bits [8i+7:8i]. Unused bytes are 0.
  - At the edge sampling byte n-1: return to IDLE and assert the ack with the assembled word. Latency is n+1 edges after the grant edge (4-byte read: ack high in the cycle after edge 5).
- WR:
  - At edge grant+i (i=1..n-1): ram_addr +1, ram_dout <= byte i.
  - At edge grant+n: ram_wr <= 0, ram_addr <= 0, ls_ack <= 1, return to IDLE.
  - Write latency is n edges.
- flush:
  - During an IF transaction, the bus sequence completes normally but if_ack is suppressed.
  - Sampled at any edge in RD, or at the grant edge.
  - LS transactions are never aborted.
- ls_size and data inputs are sampled only at the grant edge. Later changes are ignored.
- I/O reads are not gated by io_buffer_full.

Test Plan:
- IF only, if_addr=0x100, RAM bytes 13,00,00,93 → ram_addr sequence 0x100..0x103 then 0; if_ack at edge 5 after grant, if_data=0x93000013.
- LS write size 2, addr 0x1002, wdata 0xAABBCCDD → ram_wr=1 with (0x1002,DD), (0x1003,CC) on consecutive cycles; ls_ack at edge 2; no RAM access to 0x1004.
- if_req and ls_req held continuously with LS byte reads → IF granted after exactly STARVE_MAX=4 LS grants; starve counter 0 afterwards.
- LS write to 0x30000 with io_buffer_full=1 and if_req=1 → IF granted, LS held. Drop io_buffer_full → LS granted at next IDLE arbitration.
- flush asserted 2 cycles into IF read → 4 byte reads still issued, if_ack stays 0, busy falls after completion.
- rst during WR after byte 1 → next cycle all outputs 0, state IDLE, no ls_ack. rdy low mid-RD for 3 cycles → ram_addr frozen, ack latency extended by exactly 3.
